stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning the width of the bus and of each stack entry.
REQ-002 The module SHALL have parameter DEPTH, default 16, meaning the number of entries; legal values are powers of two >= 2.
REQ-003 The module SHALL use the localparam ADDR_W = $clog2(DEPTH), which is derived and not overridable.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 bus  inout  DATA_WIDTH  shared tri-state system bus; the block drives it only while STK_write=1.
REQ-007 STK_read  input  1  push: capture the bus value onto the stack at the next edge.
REQ-008 STK_write  input  1  drive the top-of-stack onto the bus, combinationally, in the same cycle.
REQ-009 STK_pop  input  1  discard the top entry at the next edge.
REQ-010 STK_clear  input  1  empty the stack at the next edge.
REQ-011 STK_err_clear  input  1  clear both sticky error flags at the next edge.
REQ-012 STK_count  output  ADDR_W+1  number of valid entries, 0..DEPTH.
REQ-013 STK_empty  output  1  high when STK_count==0.
REQ-014 STK_full  output  1  high when STK_count==DEPTH.
REQ-015 STK_overflow  output  1  sticky flag: a push was attempted while the stack was full.
REQ-016 STK_underflow  output  1  sticky flag: a pop was attempted while the stack was empty.

Function
REQ-017 Storage SHALL be DEPTH x DATA_WIDTH registers; the stack pointer sp SHALL equal STK_count, and the top entry SHALL be mem[sp-1].
REQ-018 When STK_write=1 and the stack is not empty, bus SHALL equal mem[sp-1] in the same cycle.
REQ-019 When STK_write=1 and the stack is empty, the block SHALL drive bus to all zeros; when STK_write=0, bus SHALL be high-Z.
REQ-020 Push only (STK_read=1, STK_pop=0, not full): mem[sp]<=bus and sp<=sp+1; the new value is visible on the following cycle.
REQ-021 Push while full: storage and sp SHALL be unchanged, and STK_overflow<=1.
REQ-022 Pop only (STK_pop=1, STK_read=0, not empty): sp<=sp-1; the popped entry's content need not be cleared.
REQ-023 Pop while empty: sp SHALL be unchanged, and STK_underflow<=1.
REQ-024 Push and pop in the same cycle with the stack not empty SHALL be a replace: mem[sp-1]<=bus with sp unchanged; this is legal when full and SHALL NOT set overflow.
REQ-025 Push and pop in the same cycle with the stack empty SHALL behave as a push only and SHALL NOT set underflow.
REQ-026 STK_clear SHALL set sp<=0 and override STK_read/STK_pop in that cycle; it SHALL NOT set any error flag and SHALL NOT alter the error flags.
REQ-027 STK_err_clear SHALL clear both flags; if a new error condition occurs in the same cycle, the set SHALL win.
REQ-028 The priority order SHALL be: reset > STK_clear > push/pop logic.
REQ-029 STK_count, STK_empty and STK_full SHALL be registered-state-derived, with no combinational path from control inputs.
REQ-030 The sp arithmetic SHALL be ADDR_W+1 bits wide and SHALL never wrap; the guards in REQ-021 and REQ-023 prevent wrap-around.
REQ-031 STK_write SHALL be independent of STK_pop; write+pop in one cycle SHALL output the old top and then remove it, which is the POP-to-register idiom.

Reset
REQ-032 On reset: sp=0, STK_count=0, STK_empty=1, STK_full=0, STK_overflow=0, STK_underflow=0, and bus released (Z) unless STK_write=1.
REQ-033 Storage contents SHALL NOT require reset.
REQ-034 Reset asserted mid-operation SHALL discard any push/pop in that cycle.

Verification
REQ-035 Reset, then push 0xA5A5_0001 and 0x0000_0002, then STK_write -> bus=0x0000_0002 and STK_count=2; write+pop -> bus=0x0000_0002, then STK_count=1 and top=0xA5A5_0001.
REQ-036 Push 16 values (DEPTH=16) -> STK_full=1 and STK_count=16; a 17th push -> STK_overflow=1, STK_count=16, top unchanged.
REQ-037 From empty, pop -> STK_underflow=1 and STK_count=0; STK_write -> bus=0; STK_err_clear -> flags=0.
REQ-038 Full stack, then push+pop with bus=0xDEAD_BEEF -> top=0xDEAD_BEEF, STK_count=16, STK_overflow=0; from empty, push+pop with 0x7 -> STK_count=1, STK_underflow=0.
REQ-039 STK_count=5, then STK_clear together with STK_read -> STK_count=0 and STK_empty=1; STK_err_clear together with a pop on empty -> STK_underflow stays 1.
REQ-040 Reset asserted in the same cycle as a push, with STK_count=3 -> STK_count=0 and all flags 0; STK_write=0 -> bus=Z. Repeat REQ-035 and REQ-036 with DATA_WIDTH=8 and DEPTH=4.

Source files
------------

// File: rtl/stack_unit.sv
// stack_unit: register-file LIFO stack attached to a shared tri-state bus.
// Push captures the bus value. Write drives the current top entry onto the bus
// in the same cycle. Overflow and underflow errors are held in sticky flags.
module stack_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  wire  [DATA_WIDTH-1:0] bus,
  input  logic                  STK_read,
  input  logic                  STK_write,
  input  logic                  STK_pop,
  input  logic                  STK_clear,
  input  logic                  STK_err_clear,
  output logic [ADDR_W:0]       STK_count,
  output logic                  STK_empty,
  output logic                  STK_full,
  output logic                  STK_overflow,
  output logic                  STK_underflow
);

  // Bus protocol: the controller owns the bus. It drives data while STK_read=1,
  // and the value is captured on the next rising edge. While STK_write=1 this
  // block drives the top entry, or zeros when empty, combinationally.
  // Otherwise the block holds the bus at high-Z. The controller must never
  // assert STK_read and STK_write together.

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_SP   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]       sp_q, sp_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_en_d;
  logic [ADDR_W-1:0]     wr_idx_d;
  logic [ADDR_W-1:0]     top_idx;
  logic                  empty, full;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == FULL_CNT);
  // When empty, top_idx wraps. That value is never used, because the bus
  // drives zeros and replace turns into push.
  assign top_idx = sp_q[ADDR_W-1:0] - ONE_IDX;

  assign bus = STK_write ? (empty ? '0 : mem_q[top_idx]) : 'z;

  assign STK_count     = sp_q;
  assign STK_empty     = empty;
  assign STK_full      = full;
  assign STK_overflow  = ovf_q;
  assign STK_underflow = unf_q;

  // Next-state decode: clear beats push/pop; a flag set beats err_clear.
  always_comb begin
    sp_d     = sp_q;
    wr_en_d  = 1'b0;
    wr_idx_d = sp_q[ADDR_W-1:0];
    ovf_d    = ovf_q & ~STK_err_clear;
    unf_d    = unf_q & ~STK_err_clear;
    if (STK_clear) begin
      sp_d = '0;
    end else if (STK_read && STK_pop) begin
      if (empty) begin
        wr_en_d = 1'b1;
        sp_d    = sp_q + ONE_SP;
      end else begin
        wr_en_d  = 1'b1;
        wr_idx_d = top_idx;
      end
    end else if (STK_read) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en_d = 1'b1;
        sp_d    = sp_q + ONE_SP;
      end
    end else if (STK_pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        sp_d = sp_q - ONE_SP;
      end
    end
  end

  // Control state: stack pointer and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is not reset, but a write in a reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (!reset && wr_en_d) begin
      mem_q[wr_idx_d] <= bus;
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed test of stack_unit in two configurations
// (32-bit x 16 and 8-bit x 4). A scoreboard queue holds the hand-computed
// expected state, and a monitor pops and compares entries mid-cycle.
module tb_stack_unit;

  typedef struct packed {
    logic [31:0] bus;
    logic [5:0]  count;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
    logic        chk_bus;
    logic        chk_z;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        rd = 1'b0, wr = 1'b0, pp = 1'b0, clr = 1'b0, eclr = 1'b0;
  logic [31:0] drv_val = '0;
  logic        chk = 1'b0;

  wire  [31:0] bus32;
  wire  [7:0]  bus8;
  logic [4:0]  cnt32;
  logic [2:0]  cnt8;
  logic        emp32, ful32, ovf32, unf32;
  logic        emp8, ful8, ovf8, unf8;

  assign bus32 = (rd && !wr && !sel) ? drv_val : 'z;
  assign bus8  = (rd && !wr && sel) ? drv_val[7:0] : 'z;

  stack_unit #(.DATA_WIDTH(32), .DEPTH(16)) dut32 (
    .clk(clk), .reset(rst), .bus(bus32),
    .STK_read(rd & ~sel), .STK_write(wr & ~sel), .STK_pop(pp & ~sel),
    .STK_clear(clr & ~sel), .STK_err_clear(eclr & ~sel),
    .STK_count(cnt32), .STK_empty(emp32), .STK_full(ful32),
    .STK_overflow(ovf32), .STK_underflow(unf32)
  );

  stack_unit #(.DATA_WIDTH(8), .DEPTH(4)) dut8 (
    .clk(clk), .reset(rst), .bus(bus8),
    .STK_read(rd & sel), .STK_write(wr & sel), .STK_pop(pp & sel),
    .STK_clear(clr & sel), .STK_err_clear(eclr & sel),
    .STK_count(cnt8), .STK_empty(emp8), .STK_full(ful8),
    .STK_overflow(ovf8), .STK_underflow(unf8)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: apply one cycle of controls just after the rising edge.
  task automatic op(input logic r, input logic p, input logic w, input logic c,
                    input logic e, input logic rs, input logic [31:0] d);
    @(posedge clk);
    #1;
    chk     = 1'b0;
    rd      = r;
    pp      = p;
    wr      = w;
    clr     = c;
    eclr    = e;
    rst     = rs;
    drv_val = d;
  endtask

  // Queue an expectation that the monitor checks in the current cycle.
  task automatic expect_st(input logic [31:0] b, input int cnt, input logic em,
                           input logic fu, input logic ov, input logic un,
                           input logic cb, input logic cz);
    exp_t e;
    e.bus = b; e.count = 6'(cnt); e.empty = em; e.full = fu;
    e.ovf = ov; e.unf = un; e.chk_bus = cb; e.chk_z = cz;
    exp_q.push_back(e);
    chk = 1'b1;
  endtask

  // Idle cycle that checks state and a released bus.
  task automatic idle_chk(input int cnt, input logic em, input logic fu,
                          input logic ov, input logic un);
    op(0, 0, 0, 0, 0, 0, 0);
    expect_st('0, cnt, em, fu, ov, un, 1'b0, 1'b1);
  endtask

  // Write cycle (optionally with pop) that checks the driven bus and state.
  task automatic write_chk(input logic p, input logic [31:0] b, input int cnt,
                           input logic em, input logic fu, input logic ov, input logic un);
    op(0, p, 1, 0, 0, 0, 0);
    expect_st(b, cnt, em, fu, ov, un, 1'b1, 1'b0);
  endtask

  // Monitor: sample the selected DUT mid-cycle and score it.
  always @(negedge clk) begin
    if (chk) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underrun: got empty queue expected an entry");
      end else begin
        exp_t e;
        logic [31:0] b_act;
        logic        z_ok;
        e = exp_q.pop_front();
        b_act = sel ? {24'h0, bus8} : bus32;
        z_ok  = sel ? (bus8 === 8'hzz) : (bus32 === 32'hzzzzzzzz);
        cmp("count", sel ? {29'h0, cnt8} : {27'h0, cnt32}, {26'h0, e.count});
        cmp("empty", {31'h0, sel ? emp8 : emp32}, {31'h0, e.empty});
        cmp("full", {31'h0, sel ? ful8 : ful32}, {31'h0, e.full});
        cmp("overflow", {31'h0, sel ? ovf8 : ovf32}, {31'h0, e.ovf});
        cmp("underflow", {31'h0, sel ? unf8 : unf32}, {31'h0, e.unf});
        if (e.chk_bus) cmp("bus_data", b_act, e.bus);
        if (e.chk_z) cmp("bus_highz", {31'h0, z_ok}, 32'h1);
      end
    end
  end

  initial begin
    // Reset, 32-bit x 16 configuration
    op(0, 0, 0, 0, 0, 1, 0);
    op(0, 0, 0, 0, 0, 1, 0);
    idle_chk(0, 1, 0, 0, 0);

    // Two pushes, read the top, then write+pop.
    op(1, 0, 0, 0, 0, 0, 32'hA5A5_0001);
    op(1, 0, 0, 0, 0, 0, 32'h0000_0002);
    write_chk(0, 32'h0000_0002, 2, 0, 0, 0, 0);
    write_chk(1, 32'h0000_0002, 2, 0, 0, 0, 0);
    write_chk(0, 32'hA5A5_0001, 1, 0, 0, 0, 0);
    op(0, 0, 0, 1, 0, 0, 0);
    idle_chk(0, 1, 0, 0, 0);

    // Fill to 16 entries, then push while full.
    for (int i = 0; i < 16; i++) op(1, 0, 0, 0, 0, 0, 32'h100 + 32'(i));
    write_chk(0, 32'h0000_010F, 16, 0, 1, 0, 0);
    op(1, 0, 0, 0, 0, 0, 32'h0000_0999);
    write_chk(0, 32'h0000_010F, 16, 0, 1, 1, 0);

    // Clear the errors, then replace the top while full.
    op(0, 0, 0, 0, 1, 0, 0);
    op(1, 1, 0, 0, 0, 0, 32'hDEAD_BEEF);
    write_chk(0, 32'hDEAD_BEEF, 16, 0, 1, 0, 0);

    // Underflow from empty, bus zeros, then clear the error.
    op(0, 0, 0, 1, 0, 0, 0);
    op(0, 1, 0, 0, 0, 0, 0);
    write_chk(0, 32'h0, 0, 1, 0, 0, 1);
    op(0, 0, 0, 0, 1, 0, 0);
    idle_chk(0, 1, 0, 0, 0);

    // Push+pop on empty acts as a push.
    op(1, 1, 0, 0, 0, 0, 32'h7);
    write_chk(0, 32'h7, 1, 0, 0, 0, 0);

    // Clear overrides a simultaneous push.
    op(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) op(1, 0, 0, 0, 0, 0, 32'h50 + 32'(i));
    write_chk(0, 32'h54, 5, 0, 0, 0, 0);
    op(1, 0, 0, 1, 0, 0, 32'h55);
    idle_chk(0, 1, 0, 0, 0);

    // A set wins over err_clear in the same cycle.
    op(0, 1, 0, 0, 0, 0, 0);
    op(0, 1, 0, 0, 1, 0, 0);
    idle_chk(0, 1, 0, 0, 1);
    op(0, 0, 0, 0, 1, 0, 0);
    idle_chk(0, 1, 0, 0, 0);

    // Reset together with a push at count 3, with underflow set.
    op(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) op(1, 0, 0, 0, 0, 0, 32'h30 + 32'(i));
    idle_chk(3, 0, 0, 0, 1);
    op(1, 0, 0, 0, 0, 1, 32'h77);
    idle_chk(0, 1, 0, 0, 0);

    // 8-bit x 4 configuration
    op(0, 0, 0, 0, 0, 1, 0);
    sel = 1'b1;
    op(0, 0, 0, 0, 0, 1, 0);
    idle_chk(0, 1, 0, 0, 0);
    op(1, 0, 0, 0, 0, 0, 32'hA5A5_0001);
    op(1, 0, 0, 0, 0, 0, 32'h0000_0002);
    write_chk(0, 32'h02, 2, 0, 0, 0, 0);
    write_chk(1, 32'h02, 2, 0, 0, 0, 0);
    write_chk(0, 32'h01, 1, 0, 0, 0, 0);
    op(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) op(1, 0, 0, 0, 0, 0, 32'h10 + 32'(i));
    write_chk(0, 32'h13, 4, 0, 1, 0, 0);
    op(1, 0, 0, 0, 0, 0, 32'h99);
    write_chk(0, 32'h13, 4, 0, 1, 1, 0);

    // Drain the final expectation, then make sure nothing is left queued.
    op(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cmp("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
